// File: rtl/seq_mux_if.sv
// seq_mux_if: bundles the data, handshake and status signals of seq_mux_nx1.
//   in_bus/sel/mode/in_valid/start/out_ready : driven by the master (requester)
//   in_ready/out_data/out_idx/out_valid/busy/done/sel_err : driven by the slave (mux)
//   out_par : present only when SEQ_MUX_PARITY_EN is defined
interface seq_mux_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 16
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] in_bus;
    logic [SEL_W-1:0]          sel;
    logic                      mode;
    logic                      in_valid;
    logic                      in_ready;
    logic                      start;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_idx;
    logic                      out_valid;
    logic                      out_ready;
    logic                      busy;
    logic                      done;
    logic                      sel_err;
`ifdef SEQ_MUX_PARITY_EN
    logic                      out_par;
`endif

    modport slave (
        input  in_bus, sel, mode, in_valid, start, out_ready,
        output in_ready, out_data, out_idx, out_valid, busy, done, sel_err
`ifdef SEQ_MUX_PARITY_EN
        , output out_par
`endif
    );

    modport master (
        output in_bus, sel, mode, in_valid, start, out_ready,
        input  in_ready, out_data, out_idx, out_valid, busy, done, sel_err
`ifdef SEQ_MUX_PARITY_EN
        , input out_par
`endif
    );
endinterface

// File: rtl/seq_mux_nx1.sv
// seq_mux_nx1: N-to-1 channel mux with a direct (select) mode and a scan mode
// that snapshots all channels and streams them out in order.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_mux_if.slave (inputs, valid/ready output register, status)
//   Optional macro SEQ_MUX_PARITY_EN adds bus.out_par, even parity of out_data.
module seq_mux_nx1 #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 16
) (
    input logic      clk,
    input logic      rst_n,
    seq_mux_if.slave bus
);
    localparam int SEL_W = $clog2(CHANNELS);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t                    state, state_d;
    logic [SEL_W-1:0]          idx;
    logic [CHANNELS*WIDTH-1:0] snap;
    logic                      slot_free, load_d, load_s, take, sel_bad;
    logic [WIDTH-1:0]          data_d;

    assign slot_free    = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = state == IDLE && !bus.mode && slot_free;
    assign bus.busy     = state != IDLE;
    assign load_d       = bus.in_valid && bus.in_ready;
    assign load_s       = state == SCAN && slot_free;
    assign take         = state == IDLE && bus.mode && bus.start;
    assign sel_bad      = int'(bus.sel) >= CHANNELS;
    // Out-of-range selects never reach the part-select result.
    assign data_d = load_s  ? snap[idx*WIDTH +: WIDTH] :
                    sel_bad ? '0 : bus.in_bus[bus.sel*WIDTH +: WIDTH];

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = take ? SCAN : IDLE;
            SCAN:    state_d = (load_s && idx == SEL_W'(CHANNELS-1)) ? DRAIN : SCAN;
            DRAIN:   state_d = (bus.out_valid && bus.out_ready) ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      idx <= '0;
        else if (take)   idx <= '0;
        else if (load_s) idx <= idx + 1'b1;
    end

    // Snapshot survives reset on purpose; it is reloaded on every scan start.
    always_ff @(posedge clk) begin
        if (take) snap <= bus.in_bus;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_data  <= '0;
            bus.out_idx   <= '0;
            bus.out_valid <= 1'b0;
            bus.sel_err   <= 1'b0;
            bus.done      <= 1'b0;
`ifdef SEQ_MUX_PARITY_EN
            bus.out_par   <= 1'b0;
`endif
        end else begin
            bus.done <= state == DRAIN && bus.out_valid && bus.out_ready;
            if (load_d || load_s) begin
                bus.out_data  <= data_d;
                bus.out_idx   <= load_s ? idx : bus.sel;
                bus.out_valid <= 1'b1;
                bus.sel_err   <= load_d && sel_bad;
`ifdef SEQ_MUX_PARITY_EN
                bus.out_par   <= ^data_d;
`endif
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
                bus.sel_err   <= 1'b0;
            end
        end
    end
endmodule

// File: doc/seq_mux_nx1.md
SEQ_MUX_NX1 -- requirements
Module: seq_mux_nx1

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of each channel word.
REQ-002 SHALL have parameter CHANNELS, default 16, number of input channels, legal range 2..64.
REQ-003 SHALL derive localparam SEL_W = clog2(CHANNELS), the select and index width.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_bus, input, CHANNELS*WIDTH, packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port sel, input, SEL_W, channel select in direct mode.
REQ-009 SHALL have port mode, input, 1, operating mode: 0 selects direct, 1 selects scan.
REQ-010 SHALL have port in_valid, input, 1, direct-mode request.
REQ-011 SHALL have port in_ready, output, 1, direct-mode request accepted.
REQ-012 SHALL have port start, input, 1, scan-mode start strobe.
REQ-013 SHALL have ports out_data (WIDTH), out_idx (SEL_W), out_valid (1), all outputs, forming the registered result.
REQ-014 SHALL have port out_ready, input, 1, downstream accept.
REQ-015 SHALL have ports busy (1) and done (1), outputs, giving scan status.
REQ-016 SHALL have port sel_err, output, 1, set when a direct request carries sel >= CHANNELS.

Function
REQ-017 SHALL implement FSM states IDLE, SCAN and DRAIN.
REQ-018 SHALL define slot_free = !out_valid || out_ready.
REQ-019 SHALL drive in_ready = (state==IDLE) && !mode && slot_free.
REQ-020 SHALL, on in_valid && in_ready, load out_data = channel[sel], out_idx = sel and out_valid = 1 at the next edge, giving 1-cycle latency.
REQ-021 SHALL, for a direct request with sel >= CHANNELS, load out_data = 0 and set sel_err = 1 with that word; sel_err SHALL stay valid until the word is accepted.
REQ-022 SHALL hold out_data, out_idx and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL clear out_valid on out_valid && out_ready when no new load occurs in the same cycle.
REQ-024 SHALL, on start with mode==1 in IDLE, snapshot in_bus into an internal CHANNELS*WIDTH buffer, reset the scan index to 0 and enter SCAN.
REQ-025 SHALL ignore start in SCAN or DRAIN.
REQ-026 SHALL ignore start when mode==0.
REQ-027 SHALL, in SCAN on each cycle with slot_free, load buffer[idx] and idx into the output register and increment idx.
REQ-028 SHALL enter DRAIN after loading idx = CHANNELS-1.
REQ-029 SHALL emit the first scan word with out_valid high 2 cycles after the start edge.
REQ-030 SHALL emit CHANNELS words on consecutive cycles when out_ready is held high.
REQ-031 SHALL, in DRAIN, on acceptance of the last word, pulse done for exactly 1 cycle and return to IDLE.
REQ-032 SHALL drive busy = 1 in SCAN and DRAIN.
REQ-033 SHALL not let in_bus changes during a scan affect the emitted words.
REQ-034 SHALL drive sel_err = 0 for all scan words.

Reset
REQ-035 SHALL, while rst_n is low, force state = IDLE, idx = 0, out_data = 0, out_idx = 0, out_valid = 0, sel_err = 0, done = 0 and busy = 0.
REQ-036 SHALL abort an in-progress scan on reset assertion with no done pulse.
REQ-037 SHALL not clear the snapshot buffer on reset.

Configuration
REQ-038 SHALL, with macro SEQ_MUX_PARITY_EN defined, add output out_par (1) = even parity (XOR) of out_data, registered with out_data and reset to 0.
REQ-039 SHALL, without SEQ_MUX_PARITY_EN, have no out_par port and no parity logic.

Verification
REQ-040 Direct: WIDTH=8, CHANNELS=16, channel k = 8'h10+k, sel=5, in_valid pulse -> next cycle out_valid=1, out_data=8'h15, out_idx=5.
REQ-041 Backpressure: out_ready=0 for 3 cycles after REQ-040 -> in_ready=0, outputs stable; first cycle with out_ready=1 -> word accepted.
REQ-042 Scan: mode=1, start pulse, out_ready=1, in_bus changed on the cycle after start -> 16 consecutive words 8'h10..8'h1F with idx 0..15, then a single-cycle done.
REQ-043 Out of range: CHANNELS=12, sel=13 -> out_data=0, sel_err=1.
REQ-044 Reset at the 6th scan word -> all outputs 0 and busy=0 next cycle, no done; a new start then scans from idx 0.
REQ-045 With SEQ_MUX_PARITY_EN: out_data=8'h07 -> out_par=1; out_data=8'h03 -> out_par=0.
